// File: rtl/hella_cache_slave_mem.sv
// HellaCache-style memory responder. Requests are captured into stage A,
// executed one cycle later against a local word memory, and their results
// wait in an in-order response queue until their latency timer expires.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready. req_ready depends only on registered occupancy and
// reset, never on req_valid or on the current cycle's pop. req_data and
// req_kill belong to the request accepted on the previous edge. The response
// side has no ready: rsp_valid/rsp_nack pulse for exactly one cycle per
// surviving request.
module hella_cache_slave_mem #(
  parameter int NUM_ADDR_BITS = 32,
  parameter int NUM_DATA_BITS = 32,
  parameter int NUM_TAG_BITS  = 7,
  parameter int MEM_WORDS     = 1024,
  parameter int RSP_LATENCY   = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int NACK_EVERY    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_ADDR_BITS-1:0]   req_addr,
  output logic                       req_ready,
  input  logic                       req_valid,
  input  logic [NUM_TAG_BITS-1:0]    req_tag,
  input  logic [4:0]                 req_cmd,
  input  logic [2:0]                 req_typ,
  input  logic [NUM_DATA_BITS-1:0]   req_data,
  input  logic [NUM_DATA_BITS/8-1:0] req_data_mask,
  input  logic                       req_kill,
  output logic                       rsp_valid,
  output logic                       rsp_nack,
  output logic [NUM_TAG_BITS-1:0]    rsp_tag,
  output logic [2:0]                 rsp_typ,
  output logic [NUM_DATA_BITS-1:0]   rsp_data
);

  localparam int NB    = NUM_DATA_BITS / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int TMR_W = $clog2(RSP_LATENCY + 1);
  localparam int NCT_W = (NACK_EVERY > 0) ? $clog2(NACK_EVERY + 1) : 1;

  // Stage A: request accepted last cycle, executing this cycle
  logic                    a_valid;
  logic [OFF_W-1:0]        a_off;
  logic [IDX_W-1:0]        a_idx;
  logic [NUM_TAG_BITS-1:0] a_tag;
  logic [4:0]              a_cmd;
  logic [2:0]              a_typ;
  logic [NB-1:0]           a_mask;

  // Response queue (circular buffer) with per-entry latency timers
  logic                     q_nack [QUEUE_DEPTH];
  logic [NUM_TAG_BITS-1:0]  q_tag  [QUEUE_DEPTH];
  logic [2:0]               q_typ  [QUEUE_DEPTH];
  logic [NUM_DATA_BITS-1:0] q_data [QUEUE_DEPTH];
  logic [TMR_W-1:0]         q_tmr  [QUEUE_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         q_count;

  logic [NUM_DATA_BITS-1:0] mem [MEM_WORDS];
  logic [NCT_W-1:0]         ncnt;

  logic                     accept;
  logic                     exec;
  logic                     push;
  logic                     pop;
  logic                     head_due;
  logic                     nack_tick;
  logic [NCT_W-1:0]         ncnt_next;
  logic [31:0]              size_int;
  logic [OFF_W-1:0]         align_mask;
  logic                     size_bad;
  logic                     cmd_bad;
  logic                     misalign;
  logic                     nack;
  logic [NUM_DATA_BITS-1:0] rd_word;
  logic [NUM_DATA_BITS-1:0] shifted;
  logic                     sign_bit;
  logic [NUM_DATA_BITS-1:0] ld_data;
  logic [NUM_DATA_BITS-1:0] push_data;
  logic [CNT_W:0]           occ;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^req_addr[NUM_ADDR_BITS-1:OFF_W+IDX_W];

  // Credits come only from registered occupancy, so a pop frees a slot next cycle
  always_comb begin
    occ       = {1'b0, q_count} + {{CNT_W{1'b0}}, a_valid};
    req_ready = (occ < (CNT_W+1)'(QUEUE_DEPTH)) & ~reset;
    accept    = req_valid & req_ready;
  end

  // Nack counter advances once per executed (non-killed) request
  always_comb begin
    exec      = a_valid & ~req_kill;
    nack_tick = 1'b0;
    ncnt_next = ncnt;
    if (exec && (NACK_EVERY != 0)) begin
      if (ncnt == NCT_W'(NACK_EVERY - 1)) begin
        nack_tick = 1'b1;
        ncnt_next = '0;
      end else begin
        ncnt_next = ncnt + 1'b1;
      end
    end
  end

  // Decide whether the executing request is rejected
  always_comb begin
    size_int   = {30'd0, a_typ[1:0]};
    align_mask = '0;
    for (int i = 0; i < OFF_W; i++) begin
      align_mask[i] = (size_int > i);
    end
    size_bad = (size_int > OFF_W);
    cmd_bad  = (a_cmd > 5'd1);
    misalign = (a_cmd == 5'd0) && ((a_off & align_mask) != '0);
    nack     = nack_tick | cmd_bad | size_bad | misalign;
  end

  // Load path: pick the addressed lane, then sign- or zero-extend it
  always_comb begin
    rd_word = mem[a_idx];
    shifted = rd_word >> {a_off, 3'b000};
    case (a_typ[1:0])
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[NUM_DATA_BITS-1];
    endcase
    for (int i = 0; i < NUM_DATA_BITS; i++) begin
      ld_data[i] = (i < (8 << size_int)) ? shifted[i] : (sign_bit & ~a_typ[2]);
    end
    push      = exec;
    push_data = (nack || (a_cmd != 5'd0)) ? '0 : ld_data;
  end

  // Head of queue is presented in the cycle its timer reads one
  always_comb begin
    head_due  = (q_count != '0) && (q_tmr[rd_ptr] == TMR_W'(1));
    pop       = head_due;
    rsp_valid = head_due & ~q_nack[rd_ptr] & ~reset;
    rsp_nack  = head_due & q_nack[rd_ptr] & ~reset;
    rsp_tag   = (head_due && !reset) ? q_tag[rd_ptr]  : '0;
    rsp_typ   = (head_due && !reset) ? q_typ[rd_ptr]  : '0;
    rsp_data  = (head_due && !reset) ? q_data[rd_ptr] : '0;
  end

  // Control state: stage A valid, queue pointers, timers, nack counter
  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
      ncnt    <= '0;
      for (int e = 0; e < QUEUE_DEPTH; e++) begin
        q_tmr[e] <= '0;
      end
    end else begin
      a_valid <= accept;
      ncnt    <= ncnt_next;
      for (int e = 0; e < QUEUE_DEPTH; e++) begin
        if (q_tmr[e] > TMR_W'(1)) begin
          q_tmr[e] <= q_tmr[e] - 1'b1;
        end
      end
      if (push) begin
        q_tmr[wr_ptr] <= TMR_W'(RSP_LATENCY);
        wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Request fields and queue payloads need no reset; validity lives above
  always_ff @(posedge clock) begin
    if (accept) begin
      a_off  <= req_addr[OFF_W-1:0];
      a_idx  <= req_addr[OFF_W +: IDX_W];
      a_tag  <= req_tag;
      a_cmd  <= req_cmd;
      a_typ  <= req_typ;
      a_mask <= req_data_mask;
    end
    if (push) begin
      q_nack[wr_ptr] <= nack;
      q_tag[wr_ptr]  <= a_tag;
      q_typ[wr_ptr]  <= a_typ;
      q_data[wr_ptr] <= push_data;
    end
  end

  // Store path: byte-enabled write of a surviving, non-nacked store
  always_ff @(posedge clock) begin
    if (exec && !nack && (a_cmd == 5'd1)) begin
      for (int b = 0; b < NB; b++) begin
        if (a_mask[b]) begin
          mem[a_idx][b*8 +: 8] <= req_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_hella_cache_slave_mem.sv
// Bench for hella_cache_slave_mem: directed scenarios plus randomized traffic
// scored against a byte-level memory model and an expected-response queue.
module tb_hella_cache_slave_mem;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 7;
  localparam int MW  = 1024;
  localparam int LAT = 4;
  localparam int QD  = 2;
  localparam int NE  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic          req_ready;
  logic          req_valid = 1'b0;
  logic [TW-1:0] req_tag = '0;
  logic [4:0]    req_cmd = '0;
  logic [2:0]    req_typ = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0]    req_data_mask = '0;
  logic          req_kill = 1'b0;
  logic          rsp_valid;
  logic          rsp_nack;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    rsp_typ;
  logic [DW-1:0] rsp_data;

  hella_cache_slave_mem #(
    .NUM_ADDR_BITS(AW), .NUM_DATA_BITS(DW), .NUM_TAG_BITS(TW), .MEM_WORDS(MW),
    .RSP_LATENCY(LAT), .QUEUE_DEPTH(QD), .NACK_EVERY(NE)
  ) dut (
    .clock(clock), .reset(reset), .req_addr(req_addr), .req_ready(req_ready),
    .req_valid(req_valid), .req_tag(req_tag), .req_cmd(req_cmd), .req_typ(req_typ),
    .req_data(req_data), .req_data_mask(req_data_mask), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_tag(rsp_tag),
    .rsp_typ(rsp_typ), .rsp_data(rsp_data)
  );

  // Clock and cycle index
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic        dc;
    logic [31:0] due;
    logic        nack;
    logic [6:0]  tag;
    logic [2:0]  typ;
    logic [31:0] data;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  logic [7:0]    mem_m[int];
  int            ncnt_m = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  // Previously accepted request, executed by the model in the following cycle
  bit          p_acc = 0;
  logic [4:0]  p_cmd;
  logic [2:0]  p_typ;
  logic [31:0] p_addr;
  logic [6:0]  p_tag;
  logic [3:0]  p_mask;
  logic [31:0] p_data;
  bit          p_kill;
  int          p_cyc;
  int          last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: apply the request's effect and predict its response
  task automatic model_exec();
    exp_t        e;
    bit          nk;
    int          nbytes;
    int          base;
    int          bi;
    logic [31:0] val;
    if (p_kill) return;
    ncnt_m++;
    nk = 0;
    if (ncnt_m == NE) begin
      nk = 1;
      ncnt_m = 0;
    end
    nbytes = 1 << p_typ[1:0];
    if (p_cmd > 1) nk = 1;
    if (nbytes > 4) nk = 1;
    if (p_cmd == 0 && (p_addr % nbytes) != 0) nk = 1;
    base = int'((p_addr >> 2) % MW) * 4;
    e.dc = 0;
    e.data = '0;
    if (!nk && p_cmd == 1) begin
      for (int b = 0; b < 4; b++) if (p_mask[b]) mem_m[base + b] = p_data[8*b +: 8];
    end
    if (!nk && p_cmd == 0) begin
      val = '0;
      for (int k = 0; k < nbytes; k++) begin
        bi = base + int'(p_addr % 4) + k;
        if (!mem_m.exists(bi)) e.dc = 1;
        else val |= 32'(mem_m[bi]) << (8 * k);
      end
      if (!p_typ[2] && nbytes < 4 && val[8*nbytes-1]) val |= 32'hFFFF_FFFF << (8 * nbytes);
      e.data = val;
    end
    e.due  = 32'(p_cyc + 1 + LAT);
    e.nack = nk;
    e.tag  = p_tag;
    e.typ  = p_typ;
    exp_q.push_back(EW'(e));
  endtask

  // Driver: one call per cycle; also supplies data/kill for the previous request
  task automatic drive(input bit v, input logic [4:0] cmd, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [6:0] tag, input logic [3:0] mask,
                       input logic [31:0] data, input bit kill);
    bit acc;
    bit done;
    int waited;
    if (p_acc) begin
      req_data = p_data;
      req_kill = p_kill;
      model_exec();
    end else begin
      req_data = $urandom;
      req_kill = 1'($urandom_range(0, 1));
    end
    p_acc = 0;
    req_valid = v;
    req_cmd = cmd;
    req_typ = typ;
    req_addr = addr;
    req_tag = tag;
    req_data_mask = mask;
    acc = 0;
    done = 0;
    waited = 0;
    while (!done) begin
      @(negedge clock);
      if (v && req_ready) begin
        acc = 1;
        p_cyc = cyc;
        last_acc = cyc;
      end
      @(posedge clock);
      #1;
      if (!v || acc) done = 1;
      else begin
        req_kill = 1'b0;
        req_data = $urandom;
        waited++;
        if (waited > 40) begin
          check("accept_timeout", 0, 1);
          done = 1;
        end
      end
    end
    req_valid = 1'b0;
    if (acc) begin
      p_acc = 1; p_cmd = cmd; p_typ = typ; p_addr = addr; p_tag = tag;
      p_mask = mask; p_data = data; p_kill = kill;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, '0, '0, '0, '0, '0, '0, 0);
  endtask

  task automatic flush();
    int guard;
    guard = 0;
    idle(1);
    while (exp_q.size() != 0 && guard < 60) begin
      idle(1);
      guard++;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    req_valid = 1'b0;
    req_kill = 1'b0;
    p_acc = 0;
    exp_q.delete();
    ncnt_m = 0;
    repeat (ncyc) begin
      @(negedge clock);
      check("ready_in_reset", req_ready, 0);
      check("rsp_valid_in_reset", rsp_valid, 0);
      check("rsp_nack_in_reset", rsp_nack, 0);
      check("rsp_tag_in_reset", rsp_tag, 0);
      check("rsp_data_in_reset", rsp_data, 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", req_ready, 1);
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every response must match the head of the expected queue
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (rsp_valid || rsp_nack) begin
        check("rsp_exclusive", rsp_valid & rsp_nack, 0);
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = exp_t'(exp_q.pop_front());
          check("rsp_cycle", cyc, e.due);
          check("rsp_nack", rsp_nack, e.nack);
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_typ", rsp_typ, e.typ);
          if (!e.dc) check("rsp_data", rsp_data, e.data);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_t'(exp_q[0]);
        if (e.due <= 32'(cyc)) begin
          check("missing_rsp", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c1, c2, c3;
    logic [4:0] cmd;
    int r;
    @(posedge clock);
    #1;
    do_reset(3);

    // store then load of the same word
    drive(1, 5'd1, 3'd2, 32'h1000, 7'd3, 4'hF, 32'hDEAD_BEEF, 0);
    drive(1, 5'd0, 3'd2, 32'h1000, 7'd4, 4'h0, 32'h0, 0);
    flush();

    // byte loads, signed then unsigned; memory survives reset
    do_reset(2);
    drive(1, 5'd0, 3'd0, 32'h1003, 7'd5, 4'h0, 32'h0, 0);
    drive(1, 5'd0, 3'd4, 32'h1003, 7'd6, 4'h0, 32'h0, 0);
    flush();

    // killed store leaves prior contents
    do_reset(2);
    drive(1, 5'd1, 3'd2, 32'h1004, 7'd7, 4'hF, 32'h1122_3344, 0);
    drive(1, 5'd1, 3'd2, 32'h1004, 7'd8, 4'hF, 32'hAABB_CCDD, 1);
    drive(1, 5'd0, 3'd2, 32'h1004, 7'd9, 4'h0, 32'h0, 0);
    flush();

    // periodic nack: 3rd and 6th of six loads
    do_reset(2);
    for (int i = 0; i < 6; i++) drive(1, 5'd0, 3'd2, 32'h1000, 7'(10 + i), 4'h0, 32'h0, 0);
    flush();

    // full queue: ready drops after two accepts, returns the cycle after first response
    drive(1, 5'd0, 3'd2, 32'h1004, 7'd20, 4'h0, 32'h0, 0);
    c1 = last_acc;
    drive(1, 5'd0, 3'd2, 32'h1004, 7'd21, 4'h0, 32'h0, 0);
    c2 = last_acc;
    drive(1, 5'd0, 3'd2, 32'h1004, 7'd22, 4'h0, 32'h0, 0);
    c3 = last_acc;
    check("full_second_accept", c2 - c1, 1);
    check("full_third_accept", c3 - c1, LAT + 2);
    flush();

    // reset with two requests in flight: nothing may come out afterwards
    drive(1, 5'd0, 3'd2, 32'h1000, 7'd30, 4'h0, 32'h0, 0);
    drive(1, 5'd0, 3'd2, 32'h1004, 7'd31, 4'h0, 32'h0, 0);
    do_reset(2);
    idle(10);

    // randomized traffic over a small aliased region
    for (int pass = 0; pass < 2; pass++)
      for (int w = 0; w < 8; w++)
        drive(1, 5'd1, 3'd2, 32'h2000 + 32'(4 * w), 7'(w), 4'hF, $urandom, 0);
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      r = $urandom_range(0, 9);
      cmd = (r < 5) ? 5'd0 : (r < 9) ? 5'd1 : 5'($urandom_range(2, 31));
      drive(1, cmd, 3'($urandom_range(0, 7)), 32'h2000 + 32'($urandom_range(0, 31)),
            7'($urandom), 4'($urandom), $urandom, ($urandom_range(0, 7) == 0));
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
